tm11_dma: RTL and testbench

TM11_DMA -- requirements
Module: tm11_dma

---
 rtl/tm11_pkg.sv | 26 ++
 rtl/tm11_fifo.sv | 58 +++++
 rtl/tm11_dma.sv | 269 ++++++++++++++++++++++++++
 tb/tb_tm11_dma.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm11_pkg.sv
// Shared definitions for the TM11 tape-controller NPR DMA engine.
package tm11_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int BURST_MAX  = 4;

    localparam logic [1:0] DATI = 2'b00;
    localparam logic [1:0] DATO = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK,
        ST_MASTER,
        ST_DESKEW,
        ST_MSYN,
        ST_TAIL,
        ST_RELEASE
    } state_t;

    // Negative byte count steps toward zero; a lone odd byte still costs a whole word.
    function automatic logic [15:0] brc_step(input logic [15:0] brc);
        return (brc >= 16'hFFFE) ? 16'h0000 : brc + 16'd2;
    endfunction

endpackage

// File: rtl/tm11_fifo.sv
// Small synchronous FIFO with valid/ready handshakes on both sides.
module tm11_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_wr_valid,
    input  logic [W-1:0] i_wr_data,
    output logic         o_wr_ready,
    output logic         o_rd_valid,
    output logic [W-1:0] o_rd_data,
    input  logic         i_rd_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_wr;
    logic          w_rd;

    assign o_wr_ready = (r_cnt != CW'(DEPTH));
    assign o_rd_valid = (r_cnt != '0);
    assign o_rd_data  = r_mem[r_rp];
    assign w_wr       = i_wr_valid && o_wr_ready;
    assign w_rd       = o_rd_valid && i_rd_ready;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wp <= (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
            end
            if (w_rd) begin
                r_rp <= (r_rp == AW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/tm11_dma.sv
// TM11 Unibus NPR DMA master: arbitrates, moves words between memory and the ARM FIFOs.
// Define TM11_DMA_BURST_EN to keep the bus for up to BURST_MAX words per grant.
module tm11_dma
    import tm11_pkg::*;
#(
    parameter int TIMEOUT = 1000,
    parameter int DESKEW  = 15
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        start,
    input  logic        dato,
    input  logic [17:0] cma_in,
    input  logic [15:0] brc_in,
    output logic [17:0] cma_out,
    output logic [15:0] brc_out,
    output logic        busy,
    output logic        done,
    output logic        nxm,
    input  logic        fw_valid,
    input  logic [15:0] fw_data,
    output logic        fw_ready,
    output logic        fr_valid,
    output logic [15:0] fr_data,
    input  logic        fr_ready,
    output logic        npr_out_h,
    input  logic        npg_in_h,
    output logic        sack_out_h,
    output logic        bbsy_out_h,
    output logic [17:0] a_out_h,
    output logic [1:0]  c_out_h,
    output logic [15:0] d_out_h,
    output logic        msyn_out_h,
    input  logic        ssyn_in_h,
    input  logic [15:0] d_in_h
);

    localparam int TMR_MAX = (TIMEOUT > DESKEW) ? TIMEOUT : DESKEW;
    localparam int TW      = $clog2(TMR_MAX + 1);

    // states: IDLE wait start | REQ npr | ACK sack | MASTER bbsy, wait FIFO |
    //         DESKEW settle a/c/d | MSYN wait ssyn | TAIL wait ssyn drop | RELEASE drop bus
    state_t        r_state;
    state_t        w_next;

    logic          r_live;
    logic          r_dato;
    logic [17:0]   r_cma;
    logic [15:0]   r_brc;
    logic [15:0]   r_d;
    logic [TW-1:0] r_tmr;
    logic          r_nxm;
    logic          r_done;

    logic          w_accept;
    logic          w_latch;
    logic          w_load_to;
    logic          w_pop;
    logic          w_push;
    logic          w_adv;
    logic          w_nxm_set;
    logic          w_done_set;
    logic          w_burst_ok;
    logic          w_drive;
    logic [15:0]   w_brc_next;

    logic          w_fw_in_valid;
    logic          w_fw_wr_ready;
    logic          w_fw_avail;
    logic [15:0]   w_fw_head;
    logic          w_fr_space;
    logic          w_fr_valid;
    logic [15:0]   w_fr_head;
    logic          w_fifo_ok;

    assign w_fw_in_valid = fw_valid && r_live;

    tm11_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (16)
    ) u_fw (
        .i_clk      (CLOCK),
        .i_rst      (RESET),
        .i_wr_valid (w_fw_in_valid),
        .i_wr_data  (fw_data),
        .o_wr_ready (w_fw_wr_ready),
        .o_rd_valid (w_fw_avail),
        .o_rd_data  (w_fw_head),
        .i_rd_ready (w_pop)
    );

    tm11_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (16)
    ) u_fr (
        .i_clk      (CLOCK),
        .i_rst      (RESET),
        .i_wr_valid (w_push),
        .i_wr_data  (d_in_h),
        .o_wr_ready (w_fr_space),
        .o_rd_valid (w_fr_valid),
        .o_rd_data  (w_fr_head),
        .i_rd_ready (fr_ready)
    );

    assign w_fifo_ok  = r_dato ? w_fw_avail : w_fr_space;
    assign w_brc_next = brc_step(r_brc);

`ifdef TM11_DMA_BURST_EN
    logic [1:0] r_words;

    assign w_burst_ok = (r_words < 2'(BURST_MAX - 1)) && w_fifo_ok;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_words <= '0;
        end else if (r_state == ST_ACK && w_next == ST_MASTER) begin
            r_words <= '0;
        end else if (w_adv) begin
            r_words <= r_words + 1'b1;
        end
    end
`else
    assign w_burst_ok = 1'b0;
`endif

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_latch    = 1'b0;
        w_load_to  = 1'b0;
        w_pop      = 1'b0;
        w_push     = 1'b0;
        w_adv      = 1'b0;
        w_nxm_set  = 1'b0;
        w_done_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (brc_in == 16'h0000) begin
                        w_done_set = 1'b1;
                    end else begin
                        w_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (npg_in_h) begin
                    w_next = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!npg_in_h && !ssyn_in_h) begin
                    w_next = ST_MASTER;
                end
            end
            ST_MASTER: begin
                if (w_fifo_ok) begin
                    w_latch = 1'b1;
                    w_next  = ST_DESKEW;
                end
            end
            ST_DESKEW: begin
                if (r_tmr == '0) begin
                    w_load_to = 1'b1;
                    w_next    = ST_MSYN;
                end
            end
            ST_MSYN: begin
                if (ssyn_in_h) begin
                    w_pop  = r_dato;
                    w_push = !r_dato;
                    w_next = ST_TAIL;
                end else if (r_tmr == '0) begin
                    w_nxm_set = 1'b1;
                    w_next    = ST_RELEASE;
                end
            end
            ST_TAIL: begin
                if (!ssyn_in_h) begin
                    w_adv = 1'b1;
                    if (w_brc_next != 16'h0000 && w_burst_ok) begin
                        w_next = ST_MASTER;
                    end else begin
                        w_next = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                if (r_brc == 16'h0000 || r_nxm) begin
                    w_done_set = 1'b1;
                    w_next     = ST_IDLE;
                end else begin
                    w_next = ST_REQ;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_live <= 1'b0;
            r_dato <= 1'b0;
            r_cma  <= '0;
            r_brc  <= '0;
            r_d    <= '0;
            r_tmr  <= '0;
            r_nxm  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_live <= 1'b1;
            r_done <= w_done_set;
            if (w_accept) begin
                r_cma  <= cma_in & ~18'd1;
                r_brc  <= brc_in;
                r_dato <= dato;
                r_nxm  <= 1'b0;
            end
            if (w_latch) begin
                r_d   <= r_dato ? w_fw_head : 16'h0000;
                r_tmr <= TW'(DESKEW - 1);
            end else if (w_load_to) begin
                r_tmr <= TW'(TIMEOUT - 1);
            end else if (r_tmr != '0 && (r_state == ST_DESKEW || r_state == ST_MSYN)) begin
                r_tmr <= r_tmr - 1'b1;
            end
            if (w_nxm_set) begin
                r_nxm <= 1'b1;
            end
            if (w_adv) begin
                r_cma <= r_cma + 18'd2;
                r_brc <= w_brc_next;
            end
            if (r_state == ST_RELEASE) begin
                r_d <= '0;
            end
        end
    end

    // Bus lines are decoded from state so reset clears them without waiting for an edge.
    assign w_drive    = (r_state == ST_DESKEW) || (r_state == ST_MSYN) || (r_state == ST_TAIL);
    assign npr_out_h  = (r_state == ST_REQ);
    assign sack_out_h = (r_state == ST_ACK);
    assign bbsy_out_h = (r_state == ST_MASTER) || w_drive;
    assign msyn_out_h = (r_state == ST_MSYN);
    assign a_out_h    = w_drive ? r_cma : 18'd0;
    assign c_out_h    = w_drive ? (r_dato ? DATO : DATI) : 2'b00;
    assign d_out_h    = (w_drive && r_dato) ? r_d : 16'h0000;

    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign nxm      = r_nxm;
    assign cma_out  = r_cma;
    assign brc_out  = r_brc;
    assign fw_ready = w_fw_wr_ready && r_live;
    assign fr_valid = w_fr_valid;
    assign fr_data  = w_fr_valid ? w_fr_head : 16'h0000;

endmodule

// File: tb/tb_tm11_dma.sv
// Self-checking bench for tm11_dma: Unibus arbiter/memory slave models plus a transfer-level scoreboard.
module tb_tm11_dma;

    localparam int TIMEOUT = 1000;
    localparam int DESKEW  = 15;
`ifdef TM11_DMA_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        CLOCK, RESET, start, dato;
    logic [17:0] cma_in;
    logic [15:0] brc_in;
    logic [17:0] cma_out;
    logic [15:0] brc_out;
    logic        busy, done, nxm;
    logic        fw_valid, fw_ready, fr_valid, fr_ready;
    logic [15:0] fw_data, fr_data;
    logic        npr_out_h, npg_in_h, sack_out_h, bbsy_out_h, msyn_out_h, ssyn_in_h;
    logic [17:0] a_out_h;
    logic [1:0]  c_out_h;
    logic [15:0] d_out_h, d_in_h;

    tm11_dma #(.TIMEOUT(TIMEOUT), .DESKEW(DESKEW)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .start(start), .dato(dato),
        .cma_in(cma_in), .brc_in(brc_in), .cma_out(cma_out), .brc_out(brc_out),
        .busy(busy), .done(done), .nxm(nxm),
        .fw_valid(fw_valid), .fw_data(fw_data), .fw_ready(fw_ready),
        .fr_valid(fr_valid), .fr_data(fr_data), .fr_ready(fr_ready),
        .npr_out_h(npr_out_h), .npg_in_h(npg_in_h), .sack_out_h(sack_out_h),
        .bbsy_out_h(bbsy_out_h), .a_out_h(a_out_h), .c_out_h(c_out_h), .d_out_h(d_out_h),
        .msyn_out_h(msyn_out_h), .ssyn_in_h(ssyn_in_h), .d_in_h(d_in_h)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [17:0] a;
        logic [1:0]  c;
        logic [15:0] d;
    } txn_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    txn_t        exp_txn[$];
    logic [15:0] exp_fr[$];
    logic [15:0] fr_log[$];
    logic [15:0] fw_pending[$];
    logic [15:0] mem [logic [17:0]];
    int          grants = 0;
    int          slave_words = 0;
    bit          slave_en = 1'b1;
    logic [17:0] last_a;
    logic [1:0]  last_c;
    logic [15:0] last_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [17:0] a);
        if (mem.exists(a)) return mem[a];
        return a[15:0] ^ 16'o052525;
    endfunction

    function automatic int exp_grants(input int words);
        return BURST ? (words + 3) / 4 : words;
    endfunction

    // Transfer-level model: word count from the negative byte count, addresses step by 2.
    task automatic model_start(input logic [17:0] cma, input logic [15:0] brc, input logic dir);
        int          n;
        logic [17:0] ad;
        txn_t        t;
        exp_txn.delete();
        exp_fr.delete();
        fr_log.delete();
        n  = (brc == 16'h0) ? 0 : (65536 - int'(brc) + 1) / 2;
        ad = cma & ~18'd1;
        for (int k = 0; k < n; k++) begin
            t.a = ad;
            t.c = dir ? 2'b10 : 2'b00;
            if (dir) begin
                t.d = (fw_pending.size() > 0) ? fw_pending.pop_front() : 16'h0;
            end else begin
                t.d = 16'h0;
                exp_fr.push_back(mem_rd(ad));
            end
            exp_txn.push_back(t);
            ad = ad + 18'd2;
        end
    endtask

    // Arbiter: grant two cycles after NPR, withdraw grant once SACK is seen.
    initial begin
        int acnt;
        acnt = 0;
        npg_in_h = 1'b0;
        forever begin
            @(negedge CLOCK);
            if (RESET) begin
                npg_in_h = 1'b0;
                acnt = 0;
            end else if (npr_out_h && !npg_in_h) begin
                acnt++;
                if (acnt >= 2) begin
                    npg_in_h = 1'b1;
                    grants++;
                    acnt = 0;
                end
            end else if (sack_out_h && npg_in_h) begin
                npg_in_h = 1'b0;
            end
        end
    end

    // Memory slave: SSYN three cycles after MSYN, released when MSYN drops.
    initial begin
        int scnt;
        scnt = 0;
        ssyn_in_h = 1'b0;
        d_in_h = 16'h0;
        forever begin
            @(negedge CLOCK);
            if (RESET || !msyn_out_h) begin
                ssyn_in_h = 1'b0;
                d_in_h = 16'h0;
                scnt = 0;
            end else if (slave_en && !ssyn_in_h) begin
                scnt++;
                if (scnt == 3) begin
                    if (c_out_h == 2'b00) d_in_h = mem_rd(a_out_h);
                    else mem[a_out_h] = d_out_h;
                    ssyn_in_h = 1'b1;
                    slave_words++;
                end
            end
        end
    end

    // Compare process: bus transactions, FIFO output words, bus release and timing.
    initial begin
        logic p_msyn, p_bbsy;
        int   dcnt, hcnt;
        txn_t cur;
        p_msyn = 1'b0; p_bbsy = 1'b0; dcnt = 0; hcnt = 0;
        forever begin
            @(posedge CLOCK);
            #1;
            if (!RESET) begin
                if (msyn_out_h && !p_msyn) begin
                    chk("txn_expected", 32'(exp_txn.size() > 0), 32'd1);
                    if (exp_txn.size() > 0) begin
                        cur = exp_txn.pop_front();
                        chk("txn_addr", 32'(a_out_h), 32'(cur.a));
                        chk("txn_ctl",  32'(c_out_h), 32'(cur.c));
                        chk("txn_data", 32'(d_out_h), 32'(cur.d));
                    end
                    if (c_out_h == 2'b10) chk("deskew_cycles", 32'(dcnt), 32'(DESKEW));
                    last_a = a_out_h; last_c = c_out_h; last_d = d_out_h;
                    hcnt = 0;
                end
                dcnt = (c_out_h == 2'b10 && !msyn_out_h) ? dcnt + 1 : 0;
                if (msyn_out_h) hcnt++;
                if (!msyn_out_h && p_msyn && !slave_en) begin
                    chk("nxm_msyn_width", 32'(hcnt), 32'(TIMEOUT));
                    chk("nxm_flag_at_drop", 32'(nxm), 32'd1);
                end
                if (fr_valid && fr_ready) begin
                    chk("fr_expected", 32'(exp_fr.size() > 0), 32'd1);
                    if (exp_fr.size() > 0) chk("fr_data", 32'(fr_data), 32'(exp_fr.pop_front()));
                    fr_log.push_back(fr_data);
                end
                if (!bbsy_out_h && p_bbsy) begin
                    chk("bus_idle_after_release", {11'd0, msyn_out_h, a_out_h[17:0] != 18'd0, c_out_h, d_out_h}, 32'd0);
                end
            end
            p_msyn = msyn_out_h;
            p_bbsy = bbsy_out_h;
        end
    end

    task automatic start_xfer(input logic [17:0] cma, input logic [15:0] brc, input logic dir);
        @(negedge CLOCK);
        model_start(cma, brc, dir);
        cma_in = cma; brc_in = brc; dato = dir; start = 1'b1;
        @(posedge CLOCK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge CLOCK);
            #1;
        end
        chk({name, "_done_seen"}, 32'(got), 32'd1);
        @(posedge CLOCK);
        #1;
        chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    task automatic fw_push(input logic [15:0] w);
        @(negedge CLOCK);
        fw_valid = 1'b1;
        fw_data = w;
        for (int i = 0; i < 20 && !fw_ready; i++) @(negedge CLOCK);
        chk("fw_accept", 32'(fw_ready), 32'd1);
        @(posedge CLOCK);
        @(negedge CLOCK);
        fw_valid = 1'b0;
        fw_pending.push_back(w);
    endtask

    initial begin
        int g0;
        bit seen;
        RESET = 1'b1; start = 1'b0; dato = 1'b0; cma_in = '0; brc_in = '0;
        fw_valid = 1'b0; fw_data = '0; fr_ready = 1'b1;
        repeat (3) @(posedge CLOCK);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_nxm", 32'(nxm), 32'd0);
        chk("rst_cma", 32'(cma_out), 32'd0);
        chk("rst_brc", 32'(brc_out), 32'd0);
        chk("rst_bus", {npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, a_out_h != 18'd0, c_out_h, d_out_h}, 32'd0);
        chk("rst_fifo_flags", {30'd0, fw_ready, fr_valid}, 32'd0);
        @(negedge CLOCK);
        RESET = 1'b0;

        // Two-word DATI from 001000
        mem[18'o001000] = 16'o001111;
        mem[18'o001002] = 16'o002222;
        g0 = grants;
        start_xfer(18'o001000, 16'o177774, 1'b0);
        chk("dati_busy", 32'(busy), 32'd1);
        wait_done("dati", 3000);
        chk("dati_words", 32'(fr_log.size()), 32'd2);
        if (fr_log.size() == 2) begin
            chk("dati_word0", 32'(fr_log[0]), 32'o001111);
            chk("dati_word1", 32'(fr_log[1]), 32'o002222);
        end
        chk("dati_cma", 32'(cma_out), 32'o001004);
        chk("dati_brc", 32'(brc_out), 32'd0);
        chk("dati_nxm", 32'(nxm), 32'd0);
        chk("dati_grants", 32'(grants - g0), 32'(exp_grants(2)));
        chk("dati_txn_left", 32'(exp_txn.size()), 32'd0);

        // Single DATO of 123456 to 002000
        fw_push(16'o123456);
        start_xfer(18'o002000, 16'o177776, 1'b1);
        wait_done("dato", 3000);
        chk("dato_addr", 32'(last_a), 32'o002000);
        chk("dato_ctl", 32'(last_c), 32'b10);
        chk("dato_data", 32'(last_d), 32'o123456);
        chk("dato_mem", 32'(mem_rd(18'o002000)), 32'o123456);
        chk("dato_cma", 32'(cma_out), 32'o002002);
        chk("dato_brc", 32'(brc_out), 32'd0);
        chk("dato_txn_left", 32'(exp_txn.size()), 32'd0);

        // No responder: timeout, NXM, bus released, count not advanced
        slave_en = 1'b0;
        start_xfer(18'o003000, 16'o177776, 1'b0);
        wait_done("nxm", 3000);
        chk("nxm_sticky", 32'(nxm), 32'd1);
        chk("nxm_bbsy", 32'(bbsy_out_h), 32'd0);
        chk("nxm_busy", 32'(busy), 32'd0);
        chk("nxm_cma", 32'(cma_out), 32'o003000);
        chk("nxm_brc", 32'(brc_out), 32'o177776);
        chk("nxm_no_fr", 32'(fr_valid), 32'd0);
        slave_en = 1'b1;

        // Zero count: done next cycle, no arbitration, nxm cleared
        g0 = grants;
        start_xfer(18'o004000, 16'o000000, 1'b0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_nxm_cleared", 32'(nxm), 32'd0);
        @(posedge CLOCK);
        #1;
        chk("zero_done_one_cycle", 32'(done), 32'd0);
        repeat (10) @(posedge CLOCK);
        #1;
        chk("zero_no_grant", 32'(grants - g0), 32'd0);

        // Odd byte count: one word
        g0 = grants;
        start_xfer(18'o005000, 16'o177777, 1'b0);
        wait_done("odd", 3000);
        chk("odd_words", 32'(fr_log.size()), 32'd1);
        chk("odd_brc", 32'(brc_out), 32'd0);
        chk("odd_cma", 32'(cma_out), 32'o005002);
        chk("odd_grants", 32'(grants - g0), 32'(exp_grants(1)));

        // Odd start address, 18-bit wrap, start pulsed while busy
        start_xfer(18'o777777, 16'o177774, 1'b0);
        repeat (5) @(posedge CLOCK);
        @(negedge CLOCK);
        cma_in = 18'o001234; brc_in = 16'o177700; start = 1'b1;
        @(negedge CLOCK);
        start = 1'b0;
        wait_done("wrap", 3000);
        chk("wrap_last_addr", 32'(last_a), 32'd0);
        chk("wrap_cma", 32'(cma_out), 32'o000002);
        chk("wrap_brc", 32'(brc_out), 32'd0);
        chk("wrap_words", 32'(fr_log.size()), 32'd2);
        chk("wrap_txn_left", 32'(exp_txn.size()), 32'd0);

        // Eight-word DATI: grant count depends on burst build
        g0 = grants;
        start_xfer(18'o010000, 16'o177760, 1'b0);
        wait_done("burst", 5000);
        chk("burst_words", 32'(fr_log.size()), 32'd8);
        chk("burst_grants", 32'(grants - g0), BURST ? 32'd2 : 32'd8);
        chk("burst_cma", 32'(cma_out), 32'o010020);
        chk("burst_brc", 32'(brc_out), 32'd0);
        chk("burst_txn_left", 32'(exp_txn.size()), 32'd0);

        // Reset asserted mid-cycle while MSYN is up
        slave_en = 1'b0;
        start_xfer(18'o006000, 16'o177776, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge CLOCK);
            #1;
            if (msyn_out_h) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rstmid_msyn_seen", 32'(seen), 32'd1);
        repeat (3) @(posedge CLOCK);
        #3;
        RESET = 1'b1;
        #1;
        chk("rstmid_msyn", 32'(msyn_out_h), 32'd0);
        chk("rstmid_bbsy", 32'(bbsy_out_h), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_addr", 32'(a_out_h), 32'd0);
        chk("rstmid_cma", 32'(cma_out), 32'd0);
        chk("rstmid_brc", 32'(brc_out), 32'd0);
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
        slave_en = 1'b1;
        repeat (3) @(posedge CLOCK);
        #1;
        chk("rstmid_idle_after", 32'({busy, nxm, fr_valid}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
